// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: double-buffered frame, one digit per DIV-cycle slot.
// Optional anode blanking at slot start is enabled by defining SEG_SCAN_GHOST_BLANK_EN.
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int DIV          = 50000,
  parameter int DIV_W        = 16,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [8*DIGITS-1:0]   frame_i,
  input  logic                  frame_valid_i,
  output logic                  frame_ready_o,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_done_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  if (DIV < 2 || DIV > (1 << DIV_W) - 1) begin : g_bad_div
    $error("seg_scan_ctrl: DIV out of range for DIV_W");
  end
  if (BLANK_CYCLES >= DIV) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must be below DIV");
  end

  typedef enum logic {ST_OFF, ST_SCAN} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [8*DIGITS-1:0]  shadow_q, pending_q;
  logic                 pend_full_q, pend_full_d;
  logic                 ready_q, bnd_q, done_q;
  logic [7:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic                 accept, swap, boundary, slot_end, scan_on, lit;

  // Handshake: a frame transfers on any rising edge where frame_valid_i && frame_ready_o;
  // ready is a register equal to ~pend_full, so a swap and an accept never share an edge.
  assign accept   = frame_valid_i && ready_q;
  assign slot_end = (cnt_q == CNT_LAST);
  assign scan_on  = (state_q == ST_SCAN) && enable_i;

`ifdef SEG_SCAN_GHOST_BLANK_EN
  localparam logic [DIV_W-1:0] BLANK_N = DIV_W'(BLANK_CYCLES);
  assign lit = scan_on && (cnt_q >= BLANK_N);
`else
  assign lit = scan_on;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    swap     = 1'b0;
    boundary = 1'b0;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        swap  = pend_full_q;
        if (enable_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!enable_i) begin
          // Partial frame is dropped; the next enable restarts at digit 0.
          state_d = ST_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (slot_end) begin
          cnt_d    = '0;
          boundary = (idx_q == IDX_LAST);
          idx_d    = boundary ? '0 : idx_q + 1'b1;
          swap     = boundary && pend_full_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    pend_full_d = accept ? 1'b1 : (swap ? 1'b0 : pend_full_q);
  end

  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (lit) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = shadow_q[{idx_q, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q    <= '1;
      pending_q   <= '1;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      bnd_q       <= 1'b0;
      done_q      <= 1'b0;
      an_q        <= '1;
      seg_q       <= 8'hFF;
    end else begin
      if (accept) pending_q <= frame_i;
      if (swap)   shadow_q  <= pending_q;
      pend_full_q <= pend_full_d;
      ready_q     <= ~pend_full_d;
      // Delayed one extra cycle so the pulse lines up with digit 0 on the registered anodes.
      bnd_q       <= boundary;
      done_q      <= bnd_q;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign frame_ready_o = ready_q;
  assign seg_o         = seg_q;
  assign an_o          = an_q;
  assign frame_done_o  = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed and random steps checked every cycle against a
// time-based reference model (scan time t -> digit t/DIV mod DIGITS, frame boundaries every DIGITS*DIV).
module tb_seg_scan_ctrl;
  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int DIV_W  = 16;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                enable = 1'b0;
  logic [8*DIGITS-1:0] frame = '0;
  logic                frame_valid = 1'b0;
  logic                frame_ready;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .DIV_W(DIV_W), .BLANK_CYCLES(BLANK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .frame_i(frame),
    .frame_valid_i(frame_valid), .frame_ready_o(frame_ready), .seg_o(seg),
    .an_o(an), .frame_done_o(frame_done)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]        m_shown [DIGITS];
  logic [7:0]        m_pend  [DIGITS];
  bit                m_pend_full, m_on, m_arm, m_acc;
  int                m_t;
  logic [DIGITS-1:0] exp_an;
  logic [7:0]        exp_seg;
  logic              exp_ready, exp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DIGITS; k++) begin
      m_shown[k] = 8'hFF;
      m_pend[k]  = 8'hFF;
    end
    m_pend_full = 0; m_on = 0; m_arm = 0; m_acc = 0; m_t = 0;
    exp_an = '1; exp_seg = 8'hFF; exp_ready = 1'b1; exp_done = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    int slot, dig;
    bit lit, bnd;
    slot = m_t % DIV;
    dig  = (m_t / DIV) % DIGITS;
    lit  = m_on && enable;
`ifdef SEG_SCAN_GHOST_BLANK_EN
    lit  = lit && (slot >= BLANK);
`endif
    bnd   = m_on && enable && ((m_t % FRAME) == FRAME - 1);
    m_acc = frame_valid && exp_ready;
    exp_done = m_arm;
    m_arm    = bnd;
    exp_an   = lit ? ~(DIGITS'(1) << dig) : '1;
    exp_seg  = lit ? m_shown[dig] : 8'hFF;
    if (!m_on) begin
      if (m_pend_full) begin
        m_shown = m_pend;
        m_pend_full = 0;
      end
      if (enable) begin
        m_on = 1;
        m_t  = 0;
      end
    end else if (!enable) begin
      m_on = 0;
    end else begin
      if (bnd && m_pend_full) begin
        m_shown = m_pend;
        m_pend_full = 0;
      end
      m_t++;
    end
    if (m_acc) begin
      for (int k = 0; k < DIGITS; k++) m_pend[k] = frame[8*k +: 8];
      m_pend_full = 1;
    end
    exp_ready = !m_pend_full;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("ready", 32'(frame_ready), 32'(exp_ready));
    check("done", 32'(frame_done), 32'(exp_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic offer(input logic [8*DIGITS-1:0] f, input int budget);
    int n;
    frame = f;
    frame_valid = 1'b1;
    n = 0;
    m_acc = 0;
    while (!m_acc && n < budget) begin
      cycle();
      n++;
    end
    if (!m_acc) check("accept_timeout", 32'(n), 32'(0));
    frame_valid = 1'b0;
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while (!(m_on && (m_t % FRAME) == pos) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check("wait_timeout", 32'(n), 32'(0));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_an"}, 32'(an), 32'hFF);
    check({tag, "_seg"}, 32'(seg), 32'hFF);
    check({tag, "_ready"}, 32'(frame_ready), 32'h1);
    check({tag, "_done"}, 32'(frame_done), 32'h0);
  endtask

  function automatic logic [8*DIGITS-1:0] rand_frame();
    logic [8*DIGITS-1:0] r;
    for (int k = 0; k < DIGITS; k++) r[8*k +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2 reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // Test-plan frame accepted while OFF, then scanning
    offer({8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03}, 10);
    run(2);
    enable = 1'b1;
    run(2 * FRAME + 3);

    // Mid-frame offer of all 0x11: waits for the boundary
    wait_pos(12);
    offer({DIGITS{8'h11}}, 64);
    run(2 * FRAME);

    // Valid raised exactly on the boundary cycle
    wait_pos(FRAME - 1);
    frame = rand_frame();
    frame_valid = 1'b1;
    cycle();
    frame_valid = 1'b0;
    run(2 * FRAME + 4);

    // Random frames with stalls behind a full pending buffer
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(0, 40));
      offer(rand_frame(), 100);
    end
    run(FRAME + 4);

    // Enable dropped at digit 5, then re-enabled
    wait_pos(5 * DIV + 1);
    enable = 1'b0;
    run(6);
    enable = 1'b1;
    run(FRAME + 6);

    // Random enable toggles and frame offers
    for (int i = 0; i < 300; i++) begin
      if (!frame_valid && $urandom_range(0, 3) == 0) begin
        frame = rand_frame();
        frame_valid = 1'b1;
      end
      enable = ($urandom_range(0, 9) != 0);
      cycle();
      if (m_acc) frame_valid = 1'b0;
    end
    frame_valid = 1'b0;
    enable = 1'b1;
    run(10);

    // Asynchronous reset mid-scan, away from any clock edge
    offer(rand_frame(), 100);
    run(5);
    #2 rst_n = 1'b0;
    #1 reset_checks("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(FRAME + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
